// File: rtl/md_ctrl.sv
// md_ctrl: RV32M multiply/divide sequencer driving an external Booth multiplier and iterative divider.
// Optional build macro MD_ZERO_SKIP_EN: multiplies with a zero operand bypass the multiplier.
module md_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_start,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_rs1,
  input  logic [XLEN-1:0] md_rs2,
  input  logic            md_kill,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [XLEN-1:0] mult_oper_a,
  output logic [XLEN-1:0] mult_oper_b,
  output logic            mult_enable,
  output logic [1:0]      mult_sel,
  input  logic [XLEN-1:0] mult_o,
  input  logic            mult_finish,
  output logic            div_start,
  output logic            div_signed,
  output logic            div_abort,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem,
  input  logic            div_done
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_ISSUE,
    DIV_WAIT,
    SPECIAL,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt, dispatch;
  logic [XLEN-1:0] op_a, op_b, special_res;
  logic [2:0]      funct3_q;
  logic            accept;

  assign accept      = (state == IDLE || state == DONE) && md_start;
  assign mult_oper_a = op_a;
  assign mult_oper_b = op_b;
  assign mult_sel    = funct3_q[1:0];
  assign div_signed  = ~funct3_q[0];

  // Divide corner cases are resolved from the raw request so they never reach the divider.
  always_comb begin
    dispatch = MUL;
    if (md_funct3[2]) begin
      if (md_rs2 == '0 || (!md_funct3[0] && md_rs1 == MIN_NEG && md_rs2 == '1))
        dispatch = SPECIAL;
      else
        dispatch = DIV_ISSUE;
    end
`ifdef MD_ZERO_SKIP_EN
    else if (md_rs1 == '0 || md_rs2 == '0) begin
      dispatch = SPECIAL;
    end
`endif
  end

  always_comb begin
    special_res = '0;
    if (funct3_q[2]) begin
      if (op_b == '0)
        special_res = funct3_q[1] ? op_a : '1;
      else
        special_res = funct3_q[1] ? '0 : MIN_NEG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? dispatch : IDLE;
      MUL: begin
        if (md_kill)          state_nxt = IDLE;
        else if (mult_finish) state_nxt = DONE;
      end
      DIV_ISSUE: state_nxt = md_kill ? IDLE : DIV_WAIT;
      DIV_WAIT: begin
        if (md_kill)       state_nxt = IDLE;
        else if (div_done) state_nxt = DONE;
      end
      SPECIAL: state_nxt = md_kill ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    md_busy     = 1'b0;
    md_done     = 1'b0;
    mult_enable = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    case (state)
      MUL: begin
        md_busy     = 1'b1;
        mult_enable = 1'b1;
      end
      DIV_ISSUE: begin
        md_busy   = 1'b1;
        div_start = 1'b1;
      end
      DIV_WAIT: begin
        md_busy   = 1'b1;
        div_abort = md_kill;
      end
      SPECIAL: md_busy = 1'b1;
      DONE:    md_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      funct3_q  <= '0;
      md_result <= '0;
    end else begin
      if (accept) begin
        op_a     <= md_rs1;
        op_b     <= md_rs2;
        funct3_q <= md_funct3;
      end
      if (!md_kill) begin
        case (state)
          MUL:      if (mult_finish) md_result <= mult_o;
          DIV_WAIT: if (div_done)    md_result <= funct3_q[1] ? div_rem : div_quot;
          SPECIAL:  md_result <= special_res;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl with behavioural multiplier and divider models.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_start = 1'b0;
  logic [2:0]  md_funct3 = '0;
  logic [31:0] md_rs1 = '0, md_rs2 = '0;
  logic        md_kill = 1'b0;
  logic        md_busy, md_done;
  logic [31:0] md_result, mult_oper_a, mult_oper_b, mult_o;
  logic        mult_enable, mult_finish;
  logic [1:0]  mult_sel;
  logic        div_start, div_signed, div_abort, div_done;
  logic [31:0] div_quot, div_rem;

  md_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_funct3(md_funct3),
    .md_rs1(md_rs1), .md_rs2(md_rs2), .md_kill(md_kill),
    .md_busy(md_busy), .md_done(md_done), .md_result(md_result),
    .mult_oper_a(mult_oper_a), .mult_oper_b(mult_oper_b),
    .mult_enable(mult_enable), .mult_sel(mult_sel),
    .mult_o(mult_o), .mult_finish(mult_finish),
    .div_start(div_start), .div_signed(div_signed), .div_abort(div_abort),
    .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  // External multiplier model: result ready after mul_lat enabled cycles
  int mul_lat = 0;
  int en_cnt  = 0;
  logic [63:0] p_ss, p_su, p_uu;
  always_comb begin
    p_ss = {{32{mult_oper_a[31]}}, mult_oper_a} * {{32{mult_oper_b[31]}}, mult_oper_b};
    p_su = {{32{mult_oper_a[31]}}, mult_oper_a} * {32'b0, mult_oper_b};
    p_uu = {32'b0, mult_oper_a} * {32'b0, mult_oper_b};
    case (mult_sel)
      2'b00:   mult_o = p_uu[31:0];
      2'b01:   mult_o = p_ss[63:32];
      2'b10:   mult_o = p_su[63:32];
      default: mult_o = p_uu[63:32];
    endcase
  end
  always @(posedge clk) en_cnt <= mult_enable ? en_cnt + 1 : 0;
  assign mult_finish = mult_enable && (en_cnt >= mul_lat);

  // External divider model: done div_lat cycles after div_start, ignores abort
  int div_lat = 10;
  int dcnt = 0;
  logic [31:0] d_a, d_b;
  logic        d_s;
  always @(posedge clk) begin
    if (div_start) begin
      d_a  <= mult_oper_a;
      d_b  <= mult_oper_b;
      d_s  <= div_signed;
      dcnt <= div_lat;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done = (dcnt == 1);
  always_comb begin
    div_quot = '1;
    div_rem  = d_a;
    if (d_b != 0) begin
      if (d_s) begin
        div_quot = $signed(d_a) / $signed(d_b);
        div_rem  = $signed(d_a) % $signed(d_b);
      end else begin
        div_quot = d_a / d_b;
        div_rem  = d_a % d_b;
      end
    end
  end

  int          obs_done, obs_lat, obs_busy, obs_en, obs_ds, obs_ab, obs_ndone;
  logic [31:0] obs_res;
  logic [1:0]  obs_sel;
  logic        obs_dsigned;

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    md_funct3 = f3;
    md_rs1    = a;
    md_rs2    = b;
    md_start  = 1'b1;
    @(posedge clk);
    #1 md_start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    obs_done = 0; obs_lat = 0; obs_busy = 0; obs_en = 0; obs_ds = 0; obs_ab = 0;
    obs_res = 'x; obs_sel = 'x; obs_dsigned = 1'bx;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (md_busy) obs_busy++;
      if (mult_enable) begin obs_en++; obs_sel = mult_sel; end
      if (div_start) begin obs_ds++; obs_dsigned = div_signed; end
      if (div_abort) obs_ab++;
      if (md_done) begin
        obs_done = 1; obs_lat = i; obs_res = md_result;
        break;
      end
    end
  endtask

  task automatic watch_quiet(input int n);
    obs_ndone = 0;
    obs_busy  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (md_done) obs_ndone++;
      if (md_busy) obs_busy++;
    end
  endtask

  task automatic idle_align();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    repeat (2) @(negedge clk);
    tests++;
    if ({md_busy, md_done, mult_enable, div_start, div_abort} !== 5'b0 ||
        md_result !== 32'h0 || mult_oper_a !== 32'h0 || mult_oper_b !== 32'h0) begin
      fails++;
      $display("FAIL reset_values busy=%b done=%b en=%b ds=%b ab=%b res=%h a=%h b=%h required all zero",
               md_busy, md_done, mult_enable, div_start, div_abort, md_result, mult_oper_a, mult_oper_b);
    end
    @(posedge clk); #1 rst = 1'b0;
    // reset in the middle of a real divide
    div_lat = 20;
    start_op(3'b101, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if (md_busy !== 1'b0 || mult_oper_a !== 32'h0 || md_result !== 32'h0) begin
      fails++;
      $display("FAIL reset_midop busy=%b a=%h res=%h required 0", md_busy, mult_oper_a, md_result);
    end
    @(posedge clk); #1 rst = 1'b0;
    watch_quiet(25);
    tests++;
    if (obs_ndone !== 0) begin
      fails++;
      $display("FAIL reset_no_done got %0d done pulses required 0", obs_ndone);
    end
    // a multiply straight after reset still completes
    mul_lat = 0; exp = 32'd12;
    sb.push_back(exp);
    start_op(3'b000, 32'd3, 32'd4);
    wait_done(10);
    exp = sb.pop_front();
    tests++;
    if (obs_done !== 1 || obs_res !== exp) begin
      fails++;
      $display("FAIL reset_then_mul done=%0d got=%h required=%h", obs_done, obs_res, exp);
    end
    idle_align();
  endtask

  task automatic test_mul();
    logic [2:0]  f3[6]   = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000, 3'b001};
    logic [31:0] ra[6]   = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] rb[6]   = '{32'd6, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd3, 32'd3};
    logic [31:0] ex[6]   = '{32'd42, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
    int          lat[6]  = '{0, 3, 1, 0, 2, 0};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      mul_lat = lat[i];
      sb.push_back(ex[i]);
      start_op(f3[i], ra[i], rb[i]);
      wait_done(20);
      exp = sb.pop_front();
      tests++;
      if (obs_done !== 1 || obs_res !== exp) begin
        fails++;
        $display("FAIL mul_result[%0d] done=%0d got=%h required=%h", i, obs_done, obs_res, exp);
      end
      tests++;
      if (obs_lat !== lat[i] + 2 || obs_busy !== lat[i] + 1 || obs_en !== lat[i] + 1) begin
        fails++;
        $display("FAIL mul_timing[%0d] lat=%0d busy=%0d en=%0d required lat=%0d busy=en=%0d",
                 i, obs_lat, obs_busy, obs_en, lat[i] + 2, lat[i] + 1);
      end
      tests++;
      if (obs_sel !== f3[i][1:0]) begin
        fails++;
        $display("FAIL mul_sel[%0d] got=%b required=%b", i, obs_sel, f3[i][1:0]);
      end
      idle_align();
    end
  endtask

  task automatic test_zero_mul();
    logic [31:0] exp;
    int          exp_en;
`ifdef MD_ZERO_SKIP_EN
    exp_en = 0;
`else
    exp_en = 1;
`endif
    mul_lat = 0;
    sb.push_back(32'd0);
    start_op(3'b000, 32'd0, 32'd5);
    wait_done(10);
    exp = sb.pop_front();
    tests++;
    if (obs_done !== 1 || obs_res !== exp || obs_en !== exp_en) begin
      fails++;
      $display("FAIL zero_mul done=%0d got=%h en=%0d required=%h en=%0d", obs_done, obs_res, obs_en, exp, exp_en);
    end
    idle_align();
  endtask

  task automatic test_div_special();
    logic [2:0]  f3[6] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b100, 3'b110};
    logic [31:0] ra[6] = '{32'h80000000, 32'h80000000, 32'd5, 32'h1234, 32'd9, 32'd9};
    logic [31:0] rb[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] ex[6] = '{32'h80000000, 32'h0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(ex[i]);
      start_op(f3[i], ra[i], rb[i]);
      wait_done(10);
      exp = sb.pop_front();
      tests++;
      if (obs_done !== 1 || obs_res !== exp) begin
        fails++;
        $display("FAIL special_result[%0d] done=%0d got=%h required=%h", i, obs_done, obs_res, exp);
      end
      tests++;
      if (obs_ds !== 0 || obs_busy !== 1) begin
        fails++;
        $display("FAIL special_path[%0d] div_start=%0d busy=%0d required 0 and 1", i, obs_ds, obs_busy);
      end
      idle_align();
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3[6] = '{3'b110, 3'b100, 3'b101, 3'b111, 3'b101, 3'b100};
    logic [31:0] ra[6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [31:0] rb[6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFF, 32'd2};
    logic [31:0] ex[6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd14, 32'd2, 32'd0, 32'hC0000000};
    int          lt[6] = '{10, 4, 1, 7, 3, 2};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      div_lat = lt[i];
      sb.push_back(ex[i]);
      start_op(f3[i], ra[i], rb[i]);
      wait_done(40);
      exp = sb.pop_front();
      tests++;
      if (obs_done !== 1 || obs_res !== exp) begin
        fails++;
        $display("FAIL div_result[%0d] done=%0d got=%h required=%h", i, obs_done, obs_res, exp);
      end
      tests++;
      if (obs_ds !== 1 || obs_dsigned !== ~f3[i][0] || obs_lat !== lt[i] + 2) begin
        fails++;
        $display("FAIL div_handshake[%0d] starts=%0d signed=%b lat=%0d required 1 %b %0d",
                 i, obs_ds, obs_dsigned, obs_lat, ~f3[i][0], lt[i] + 2);
      end
      idle_align();
    end
  endtask

  task automatic test_kill();
    logic [31:0] res_before, exp;
    div_lat = 5;
    res_before = md_result;
    start_op(3'b101, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 md_kill = 1'b1;
    #1;
    tests++;
    if (div_abort !== 1'b1 || md_busy !== 1'b1) begin
      fails++;
      $display("FAIL kill_abort div_abort=%b busy=%b required 1 1", div_abort, md_busy);
    end
    @(posedge clk);
    #1 md_kill = 1'b0;
    tests++;
    if (md_busy !== 1'b0 || div_abort !== 1'b0) begin
      fails++;
      $display("FAIL kill_idle busy=%b div_abort=%b required 0 0", md_busy, div_abort);
    end
    watch_quiet(4);
    tests++;
    if (obs_ndone !== 0 || md_result !== res_before) begin
      fails++;
      $display("FAIL kill_no_done dones=%0d res=%h required 0 %h", obs_ndone, md_result, res_before);
    end
    mul_lat = 0;
    sb.push_back(32'd15);
    start_op(3'b000, 32'd3, 32'd5);
    wait_done(10);
    exp = sb.pop_front();
    tests++;
    if (obs_done !== 1 || obs_res !== exp || obs_lat !== 2) begin
      fails++;
      $display("FAIL kill_then_mul done=%0d got=%h lat=%0d required %h lat 2", obs_done, obs_res, obs_lat, exp);
    end
    // kill arriving in DONE leaves the pulse intact
    md_kill = 1'b1;
    #1;
    tests++;
    if (md_done !== 1'b1) begin
      fails++;
      $display("FAIL kill_in_done md_done=%b required 1", md_done);
    end
    @(posedge clk);
    #1 md_kill = 1'b0;
    idle_align();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    mul_lat = 0;
    sb.push_back(32'd6);
    start_op(3'b000, 32'd2, 32'd3);
    wait_done(10);
    exp = sb.pop_front();
    tests++;
    if (obs_done !== 1 || obs_res !== exp) begin
      fails++;
      $display("FAIL b2b_first got=%h required=%h", obs_res, exp);
    end
    sb.push_back(32'd20);
    start_op(3'b000, 32'd4, 32'd5);
    wait_done(10);
    exp = sb.pop_front();
    tests++;
    if (obs_done !== 1 || obs_res !== exp || obs_lat !== 2) begin
      fails++;
      $display("FAIL b2b_second done=%0d got=%h lat=%0d required %h lat 2", obs_done, obs_res, obs_lat, exp);
    end
    idle_align();
    // a start while busy is dropped
    mul_lat = 3;
    sb.push_back(32'd81);
    start_op(3'b000, 32'd9, 32'd9);
    start_op(3'b000, 32'd2, 32'd2);
    wait_done(20);
    exp = sb.pop_front();
    tests++;
    if (obs_done !== 1 || obs_res !== exp) begin
      fails++;
      $display("FAIL busy_ignore_result got=%h required=%h", obs_res, exp);
    end
    watch_quiet(6);
    tests++;
    if (obs_ndone !== 0 || obs_busy !== 0) begin
      fails++;
      $display("FAIL busy_ignore_extra dones=%0d busy=%0d required 0 0", obs_ndone, obs_busy);
    end
    idle_align();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_zero_mul();
    test_div_special();
    test_div();
    test_kill();
    test_back_to_back();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
